// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Handshake: the requester raises start_i and holds it until it has consumed
// ready_o; one quotient bit is produced per clock from latched operands, and
// result_o/ready_o stay valid in END until start_i falls. annul_i aborts an
// operation in progress (ON or BYZERO) and is ignored elsewhere.
module div #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // Partial remainder lives in the upper half, shifted-in quotient bits in the lower.
    logic [2*DATA_W:0]   dividend_q, dividend_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                sign1_q, sign1_d;
    logic                sign2_q, sign2_d;
    logic                signed_q, signed_d;
    logic [2*DATA_W-1:0] result_d;
    logic                ready_d;

    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   quo, rem, quo_fix, rem_fix;

    // Operand magnitudes, trial subtraction and final sign correction.
    always_comb begin
        abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        diff = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
        quo  = dividend_q[DATA_W-1:0];
        rem  = dividend_q[2*DATA_W:DATA_W+1];
        quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? -quo : quo;
        rem_fix = (signed_q && sign1_q) ? -rem : rem;
    end

    // Next-state and next-output logic of the divider FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        signed_d   = signed_q;
        result_d   = result_o;
        ready_d    = ready_o;
        case (state_q)
            FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d    = ON;
                        cnt_d      = '0;
                        divisor_d  = abs2;
                        dividend_d = {{DATA_W{1'b0}}, abs1, 1'b0};
                        sign1_d    = opdata1_i[DATA_W-1];
                        sign2_d    = opdata2_i[DATA_W-1];
                        signed_d   = signed_div_i;
                    end
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d  = FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d  = FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != CNT_LAST) begin
                    if (diff[DATA_W]) begin
                        dividend_d = dividend_q << 1;
                    end else begin
                        dividend_d = {diff[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end
            end
            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d = FREE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            signed_q   <= 1'b0;
            result_o   <= '0;
            ready_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            signed_q   <= signed_d;
            result_o   <= result_d;
            ready_o    <= ready_d;
        end
    end

endmodule

// File: tb/tb_div.sv
// Testbench for div: directed cases with literal expectations plus randomized
// operations, all compared every cycle against a transaction-level model.
module tb_div;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          signed_div = 1'b0;
    logic [W-1:0]  op1 = '0;
    logic [W-1:0]  op2 = '0;
    logic          start = 1'b0;
    logic          annul = 1'b0;
    logic [2*W-1:0] result;
    logic          ready;

    int tests = 0;
    int fails = 0;

    div #(.DATA_W(W)) dut (
        .clk(clk),
        .rst(rst),
        .signed_div_i(signed_div),
        .opdata1_i(op1),
        .opdata2_i(op2),
        .start_i(start),
        .annul_i(annul),
        .result_o(result),
        .ready_o(ready)
    );

    // Clock and reset-time setup.
    always #5 clk = ~clk;

    // Reference quotient/remainder from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = sa / sb;
            r  = sa % sb;
            qq = q[31:0];
            rr = r[31:0];
        end else begin
            qq = a / b;
            rr = a % b;
        end
        return {rr, qq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: idle / busy (edges left) / done.
    int            m_phase = 0;
    int            m_left = 0;
    logic [63:0]   m_pend = '0;
    logic          m_ready = 1'b0;
    logic [63:0]   m_result = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase  <= 0;
            m_left   <= 0;
            m_ready  <= 1'b0;
            m_result <= '0;
        end else begin
            case (m_phase)
                0: if (start && !annul) begin
                    m_pend  <= ref_div(signed_div, op1, op2);
                    m_left  <= (op2 == 0) ? 1 : 33;
                    m_phase <= 1;
                end
                1: if (annul) begin
                    m_phase <= 0;
                end else if (m_left == 1) begin
                    m_phase  <= 2;
                    m_ready  <= 1'b1;
                    m_result <= m_pend;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (!start) begin
                    m_phase  <= 0;
                    m_ready  <= 1'b0;
                    m_result <= '0;
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        check("cyc_ready", {63'd0, ready}, {63'd0, m_ready});
        check("cyc_result", result, m_result);
    end

    task automatic set_ops(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        signed_div = sgn;
        op1 = a;
        op2 = b;
    endtask

    // One operation with start held; optional operand scramble and start drop.
    task automatic run_op(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int exp_lat, input int chg_at, input int drop_at);
        int lat;
        @(negedge clk);
        #1;
        set_ops(sgn, a, b);
        start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ready) begin
                lat = i;
                break;
            end
            #1;
            if (i == chg_at) begin
                op1 = $urandom;
                op2 = $urandom;
            end
            if (i == drop_at) start = 1'b0;
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_res"}, result, exp_res);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({name, "_ready_drop"}, {63'd0, ready}, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw;
        logic sgn;
        logic [31:0] a, b;

        // Pin the reference model itself.
        check("pin_divu_100_7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        check("pin_div_m7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
        check("pin_div_7_m2", ref_div(1'b1, 32'd7, 32'hFFFFFFFE), {32'h00000001, 32'hFFFFFFFD});
        check("pin_div_min_m1", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), {32'd0, 32'h80000000});
        check("pin_divu_by0", ref_div(1'b0, 32'hFFFFFFFF, 32'd0), 64'd0);

        #2;
        check("reset_result", result, 64'd0);
        check("reset_ready", {63'd0, ready}, 64'd0);
        #10;
        rst = 1'b1;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 0, 0);
        run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0, 0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34, 0, 0);
        run_op("divu_by0", 1'b0, 32'hFFFFFFFF, 32'd0, 64'd0, 2, 0, 0);
        run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 34, 0, 0);

        // Annul pulse sampled at edge 10 of an operation.
        @(negedge clk);
        #1;
        set_ops(1'b0, 32'hFFFFFFFF, 32'd1);
        start = 1'b1;
        repeat (9) @(negedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        annul = 1'b0;
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) saw = 1;
        end
        check("annul_no_ready", 64'(saw), 64'd0);
        run_op("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 0, 0);

        // Operand changes after start and a start drop mid-operation.
        run_op("opchg_1000_10", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 34, 5, 0);
        run_op("drop_1000_10", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 34, 0, 12);

        // Asynchronous reset at edge 20 of an operation.
        @(negedge clk);
        #1;
        set_ops(1'b0, 32'd1000, 32'd7);
        start = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_result", result, 64'd0);
        check("async_rst_ready", {63'd0, ready}, 64'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        run_op("after_rst", 1'b0, 32'h12345678, 32'h100, {32'h78, 32'h00123456}, 34, 0, 0);

        // Randomized operations with occasional annul, operand churn and start drops.
        for (int n = 0; n < 60; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            @(negedge clk);
            #1;
            set_ops(sgn, a, b);
            start = 1'b1;
            annul = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (ready) break;
                #1;
                if ($urandom_range(0, 49) == 0) begin
                    annul = 1'b1;
                    start = 1'b0;
                    @(negedge clk);
                    #1;
                    annul = 1'b0;
                    break;
                end
                if ($urandom_range(0, 9) == 0) begin
                    op1 = $urandom;
                    op2 = $urandom;
                end
                if ($urandom_range(0, 29) == 0) start = 1'b0;
            end
            #1;
            start = 1'b0;
            annul = 1'b0;
            repeat (2) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
